led_status_bank: RTL and testbench

- Parametrised multi-channel status-LED driver for the AFM FPGA top level.
- Generalises the single `led` output of `top` into CHANNELS independently configured outputs.
- Per-channel modes: off, steady on, periodic blink, and repeating blink-code (N pulses then a gap), all timed from a shared tick prescaler.
- Configured through a valid/ready write port by control logic; outputs drive board LEDs directly.

---
 rtl/led_status_bank_if.sv | 31 +++
 rtl/led_status_bank.sv | 181 ++++++++++++++++++
 tb/tb_led_status_bank.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_status_bank_if.sv
// Configuration write port for led_status_bank.
//   cfg_valid : write request (master -> slave)
//   cfg_ready : write accepted when cfg_valid && cfg_ready (slave -> master)
//   cfg_chan  : target channel, CH_W bits
//   cfg_mode  : 0 OFF, 1 ON, 2 BLINK, 3 CODE
//   cfg_arg   : BLINK half-period minus 1 in ticks; CODE pulse count in [3:0]
interface led_status_bank_if #(
    parameter int unsigned CH_W = 2
) ();
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_chan;
    logic [1:0]      cfg_mode;
    logic [7:0]      cfg_arg;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_mode,
        output cfg_arg,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_mode,
        input  cfg_arg,
        output cfg_ready
    );
endinterface

// File: rtl/led_status_bank.sv
// Multi-channel status-LED driver. Each channel is independently set to
// OFF, ON, BLINK or CODE (N pulses then a gap), all timed from one shared
// free-running tick prescaler.
//   clk, rst  : clock, synchronous active-high reset
//   cfg       : configuration write port (slave side of led_status_bank_if)
//   lamp_test : forces every led bit high while asserted
//   tick      : one-cycle pulse when the prescaler wraps (debug)
//   led       : LED drive, active high
module led_status_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PRESCALE    = 100000,
    parameter int unsigned PULSE_TICKS = 200,
    parameter int unsigned GAP_TICKS   = 1000,
    parameter int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    led_status_bank_if.slave    cfg,
    input  logic                lamp_test,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    localparam int unsigned PS_W     = $clog2(PRESCALE);
    localparam int unsigned CODE_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int unsigned CT_W     = $clog2(CODE_MAX + 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CODE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_HIGH = 2'd1,
        C_LOW  = 2'd2,
        C_GAP  = 2'd3
    } code_state_e;

    logic [PS_W-1:0]     ps_cnt;
    logic                ready_q;
    logic                cfg_fire;
    logic [CH_W-1:0]     chan_sel;
    logic [CHANNELS-1:0] led_q;

    // Free-running prescaler; tick is registered one count early so it is
    // high exactly while the count sits at PRESCALE-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= (ps_cnt == PS_W'(PRESCALE - 2));
            if (ps_cnt == PS_W'(PRESCALE - 1)) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

    // Write port is always ready once out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg_fire      = cfg.cfg_valid && ready_q;
    assign chan_sel      = cfg.cfg_chan;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        mode_e           mode_q;
        logic [7:0]      arg_q;
        logic [7:0]      btimer;
        logic [CT_W-1:0] ctimer;
        logic [3:0]      pcount;
        code_state_e     cstate;
        logic            led_bit;
        logic            hit;

        // Out-of-range channel numbers match no instance and are dropped.
        assign hit = cfg_fire && (32'(chan_sel) == 32'(gi));

        // Per-channel pattern generator; a write takes priority over a
        // coincident tick so the new phase always starts from zero.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q  <= MODE_OFF;
                arg_q   <= '0;
                btimer  <= '0;
                ctimer  <= '0;
                pcount  <= '0;
                cstate  <= C_IDLE;
                led_bit <= 1'b0;
            end else if (hit) begin
                mode_q <= mode_e'(cfg.cfg_mode);
                arg_q  <= cfg.cfg_arg;
                btimer <= '0;
                ctimer <= '0;
                pcount <= '0;
                cstate <= C_IDLE;
                case (mode_e'(cfg.cfg_mode))
                    MODE_OFF:   led_bit <= 1'b0;
                    MODE_ON:    led_bit <= 1'b1;
                    MODE_BLINK: led_bit <= 1'b1;
                    MODE_CODE: begin
                        if (cfg.cfg_arg[3:0] == 4'd0) begin
                            led_bit <= 1'b0;
                        end else begin
                            cstate  <= C_HIGH;
                            led_bit <= 1'b1;
                        end
                    end
                    default:    led_bit <= 1'b0;
                endcase
            end else if (tick) begin
                case (mode_q)
                    MODE_BLINK: begin
                        if (btimer == arg_q) begin
                            led_bit <= ~led_bit;
                            btimer  <= '0;
                        end else begin
                            btimer <= btimer + 1'b1;
                        end
                    end
                    MODE_CODE: begin
                        case (cstate)
                            C_HIGH: begin
                                if (ctimer == CT_W'(PULSE_TICKS - 1)) begin
                                    cstate  <= C_LOW;
                                    led_bit <= 1'b0;
                                    ctimer  <= '0;
                                    pcount  <= pcount + 1'b1;
                                end else begin
                                    ctimer <= ctimer + 1'b1;
                                end
                            end
                            C_LOW: begin
                                if (ctimer == CT_W'(PULSE_TICKS - 1)) begin
                                    ctimer <= '0;
                                    if (pcount == arg_q[3:0]) begin
                                        cstate <= C_GAP;
                                    end else begin
                                        cstate  <= C_HIGH;
                                        led_bit <= 1'b1;
                                    end
                                end else begin
                                    ctimer <= ctimer + 1'b1;
                                end
                            end
                            C_GAP: begin
                                if (ctimer == CT_W'(GAP_TICKS - 1)) begin
                                    cstate  <= C_HIGH;
                                    led_bit <= 1'b1;
                                    ctimer  <= '0;
                                    pcount  <= '0;
                                end else begin
                                    ctimer <= ctimer + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end

        assign led_q[gi] = led_bit;
    end

    // lamp_test overrides the display only; channel state runs on underneath.
    assign led = led_q | {CHANNELS{lamp_test}};

endmodule

// File: tb/tb_led_status_bank.sv
// Self-checking bench for led_status_bank. Instance a (PRESCALE=4) covers
// reset, ON/OFF latency, BLINK timing and edge writes; instance b
// (PRESCALE=2, PULSE_TICKS=2, GAP_TICKS=5) covers CODE and lamp_test.
module tb_led_status_bank;

    localparam int unsigned CHW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       lamp_a;
    logic       lamp_b;
    logic       tick_a;
    logic       tick_b;
    logic [3:0] led_a;
    logic [3:0] led_b;

    always #5 clk = ~clk;

    led_status_bank_if #(.CH_W(CHW)) cfg_a ();
    led_status_bank_if #(.CH_W(CHW)) cfg_b ();

    led_status_bank #(
        .CHANNELS(4), .PRESCALE(4), .PULSE_TICKS(200), .GAP_TICKS(1000), .CH_W(CHW)
    ) dut_a (
        .clk(clk), .rst(rst), .cfg(cfg_a), .lamp_test(lamp_a), .tick(tick_a), .led(led_a)
    );

    led_status_bank #(
        .CHANNELS(4), .PRESCALE(2), .PULSE_TICKS(2), .GAP_TICKS(5), .CH_W(CHW)
    ) dut_b (
        .clk(clk), .rst(rst), .cfg(cfg_b), .lamp_test(lamp_b), .tick(tick_b), .led(led_b)
    );

    typedef struct {
        int         ch;
        int         mode;
        int         arg;
        logic [3:0] exp_led;
        string      name;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    vec_t       vecs [0:12];
    logic [3:0] exp_q [$];
    logic       tr_led  [0:127];
    logic       tr_tick [0:127];
    int         other_bad;
    int         tog [0:15];
    int         ntog;
    int         run_len [0:31];
    int         run_val [0:31];
    int         nruns;
    int         code_runs [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input int ch, input int mode, input int arg);
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_chan  = CHW'(ch);
        cfg_a.cfg_mode  = 2'(mode);
        cfg_a.cfg_arg   = 8'(arg);
        step();
        cfg_a.cfg_valid = 1'b0;
    endtask

    task automatic write_b(input int ch, input int mode, input int arg);
        cfg_b.cfg_valid = 1'b1;
        cfg_b.cfg_chan  = CHW'(ch);
        cfg_b.cfg_mode  = 2'(mode);
        cfg_b.cfg_arg   = 8'(arg);
        step();
        cfg_b.cfg_valid = 1'b0;
    endtask

    // Trace led_a[0] and tick_a, starting with the current cycle.
    task automatic record_a(input int n);
        other_bad = 0;
        for (int j = 0; j < n; j++) begin
            tr_led[j]  = led_a[0];
            tr_tick[j] = tick_a;
            if (led_a[3:1] != 3'b000) other_bad++;
            step();
        end
    endtask

    // Trace led_b[1] with lamp_b asserted for samples [lamp_from, lamp_to).
    task automatic record_b(input int n, input int lamp_from, input int lamp_to);
        other_bad = 0;
        for (int j = 0; j < n; j++) begin
            lamp_b = (j >= lamp_from) && (j < lamp_to);
            #1;
            tr_led[j]  = led_b[1];
            tr_tick[j] = tick_b;
            if (lamp_b) check("lamp_all_on", led_b, 4'hF);
            else if ((led_b & 4'b1101) != 4'b0000) other_bad++;
            step();
        end
        lamp_b = 1'b0;
    endtask

    task automatic analyze_toggles(input int n);
        ntog = 0;
        for (int j = 1; j < n; j++) begin
            if (tr_led[j] !== tr_led[j-1] && ntog < 16) begin
                tog[ntog] = j;
                ntog++;
            end
        end
    endtask

    // Only complete runs are recorded; the trailing run is dropped.
    task automatic analyze_runs(input int n);
        int   len;
        logic cur;
        nruns = 0;
        cur   = tr_led[0];
        len   = 1;
        for (int j = 1; j < n; j++) begin
            if (tr_led[j] === cur) begin
                len++;
            end else begin
                if (nruns < 32) begin
                    run_len[nruns] = len;
                    run_val[nruns] = int'(cur);
                end
                nruns++;
                cur = tr_led[j];
                len = 1;
            end
        end
    endtask

    function automatic int nth_tick(input int k, input int n);
        int c = 0;
        for (int j = 0; j < n; j++) begin
            if (tr_tick[j]) begin
                c++;
                if (c == k) return j;
            end
        end
        return -1;
    endfunction

    initial begin
        int mism;
        int first_tog;

        vecs[0]  = '{2, 1, 0,     4'b0100, "on_ch2"};
        vecs[1]  = '{2, 0, 0,     4'b0000, "off_ch2"};
        vecs[2]  = '{1, 1, 0,     4'b0010, "on_ch1"};
        vecs[3]  = '{3, 1, 0,     4'b1010, "on_ch3"};
        vecs[4]  = '{4, 1, 0,     4'b1010, "oob_ch4"};
        vecs[5]  = '{7, 2, 5,     4'b1010, "oob_ch7"};
        vecs[6]  = '{1, 3, 0,     4'b1000, "code_arg0_ch1"};
        vecs[7]  = '{3, 0, 0,     4'b0000, "off_ch3"};
        vecs[8]  = '{0, 2, 50,    4'b0001, "blink_start_ch0"};
        vecs[9]  = '{0, 0, 0,     4'b0000, "off_ch0"};
        vecs[10] = '{3, 3, 8'hF0, 4'b0000, "code_hinib_ch3"};
        vecs[11] = '{2, 1, 0,     4'b0100, "on_ch2_again"};
        vecs[12] = '{2, 0, 0,     4'b0000, "off_ch2_again"};
        code_runs = '{4, 4, 4, 4, 14, 4, 4, 4, 4, 4, 14};

        rst = 1'b1;
        lamp_a = 1'b0;
        lamp_b = 1'b0;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_chan = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_arg = '0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_chan = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_arg = '0;

        // Reset and idle
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_led", led_a, 4'b0000);
            check("rst_ready", cfg_a.cfg_ready, 1'b0);
            check("rst_tick", tick_a, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                check("ready_after_rst_a", cfg_a.cfg_ready, 1'b1);
                check("ready_after_rst_b", cfg_b.cfg_ready, 1'b1);
            end
            check("idle_tick_a", tick_a, (k % 4) == 3);
            check("idle_tick_b", tick_b, (k % 2) == 1);
            check("idle_led", led_a, 4'b0000);
        end

        // Table-driven writes with one-cycle latency, scoreboarded
        begin
            logic [3:0] prev_led;
            logic [3:0] want;
            prev_led = 4'b0000;
            for (int i = 0; i <= 12; i++) begin
                check({vecs[i].name, "_before"}, led_a, prev_led);
                exp_q.push_back(vecs[i].exp_led);
                write_a(vecs[i].ch, vecs[i].mode, vecs[i].arg);
                want = exp_q.pop_front();
                check(vecs[i].name, led_a, want);
                check({vecs[i].name, "_ready"}, cfg_a.cfg_ready, 1'b1);
                prev_led = want;
            end
        end

        // BLINK half-period: arg 2 -> toggle on every third tick (12 cycles)
        write_a(0, 2, 2);
        record_a(80);
        analyze_toggles(80);
        check("blink_high_after_write", tr_led[0], 1'b1);
        check("blink_toggle_count", ntog >= 4, 1'b1);
        if (ntog >= 4) begin
            check("blink_first_toggle", tog[0], nth_tick(3, 80) + 1);
            check("blink_period_1", tog[1] - tog[0], 12);
            check("blink_period_2", tog[2] - tog[1], 12);
            check("blink_period_3", tog[3] - tog[2], 12);
        end
        check("blink_others_off", other_bad, 0);

        // Rewrite BLINK mid-period (led low) -> restarts high
        for (int k = 0; k < 40 && led_a[0] !== 1'b0; k++) step();
        check("blink_found_low", led_a[0], 1'b0);
        step();
        write_a(0, 2, 2);
        record_a(40);
        analyze_toggles(40);
        check("rewrite_high", tr_led[0], 1'b1);
        first_tog = (ntog > 0) ? tog[0] : -1;
        check("rewrite_first_toggle", first_tog, nth_tick(3, 40) + 1);

        // Write coincident with a tick: that tick is not counted
        for (int k = 0; k < 8 && tick_a !== 1'b1; k++) step();
        check("tick_found", tick_a, 1'b1);
        write_a(0, 2, 2);
        record_a(40);
        analyze_toggles(40);
        first_tog = (ntog > 0) ? tog[0] : -1;
        check("coincident_high", tr_led[0], 1'b1);
        check("coincident_first_toggle", first_tog, 12);
        write_a(0, 0, 0);
        check("blink_off", led_a, 4'b0000);

        // CODE: 3 pulses of 4 cycles, 4-cycle lows, extra 10-cycle gap
        write_b(1, 3, 3);
        record_b(100, 100, 100);
        analyze_runs(100);
        check("code_run_count", nruns >= 12, 1'b1);
        check("code_others_off", other_bad, 0);
        if (nruns >= 12) begin
            check("code_run0_val", run_val[0], 1);
            check("code_run0_len", (run_len[0] >= 3) && (run_len[0] <= 4), 1'b1);
            mism = 0;
            for (int r = 1; r <= 11; r++) begin
                if (run_len[r] != code_runs[r-1]) mism++;
                if (run_val[r] != ((r % 2 == 0) ? 1 : 0)) mism++;
            end
            check("code_run_pattern", mism, 0);
            check("code_gap_len", run_len[5], 14);
        end

        write_b(1, 3, 0);
        mism = 0;
        for (int k = 0; k < 20; k++) begin
            if (led_b !== 4'b0000) mism++;
            step();
        end
        check("code_arg0_constant_off", mism, 0);

        // lamp_test during CODE: all on, pattern phase undisturbed
        write_b(1, 3, 3);
        record_b(120, 60, 66);
        mism = 0;
        for (int j = 66; j < 94; j++) if (tr_led[j] !== tr_led[j-34]) mism++;
        check("lamp_resume_vs_before", mism, 0);
        mism = 0;
        for (int j = 100; j < 120; j++) if (tr_led[j] !== tr_led[j-34]) mism++;
        check("lamp_resume_periodic", mism, 0);
        check("lamp_others_off", other_bad, 0);

        lamp_a = 1'b1;
        #1;
        check("lamp_a_on", led_a, 4'hF);
        lamp_a = 1'b0;
        #1;
        check("lamp_a_off", led_a, 4'h0);

        // Reset mid-BLINK discards configuration
        write_a(0, 2, 0);
        write_a(2, 1, 0);
        step();
        step();
        check("pre_rst_on_ch2", led_a[2], 1'b1);
        rst = 1'b1;
        step();
        check("midrst_led_a", led_a, 4'b0000);
        check("midrst_led_b", led_b, 4'b0000);
        check("midrst_ready", cfg_a.cfg_ready, 1'b0);
        check("midrst_tick", tick_a, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_ready", cfg_a.cfg_ready, 1'b1);
        mism = 0;
        for (int k = 0; k < 30; k++) begin
            if (led_a !== 4'b0000 || led_b !== 4'b0000) mism++;
            step();
        end
        check("post_rst_all_off", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
